// File: rtl/fpu_result_uart_tx.sv
// fpu_result_uart_tx: buffers FPU results in a small FIFO and streams each
// word out over a UART 8N1 line, least significant byte first.
// Optional build macro FPU_TX_FLAGS_EN adds a fifth byte {3'b000, flags}.
module fpu_result_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   clks_per_bit,
  input  logic                          result_valid,
  input  logic [31:0]                   result_data,
  input  logic [4:0]                    result_flags,
  output logic                          o_Tx_Serial,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef FPU_TX_FLAGS_EN
  localparam int WW     = 37;
  localparam int NBYTES = 5;
  logic [WW-1:0] in_word;
  assign in_word = {result_flags, result_data};
`else
  localparam int WW     = 32;
  localparam int NBYTES = 4;
  logic [WW-1:0] in_word;
  logic          unused_flags;
  assign in_word      = result_data;
  assign unused_flags = ^result_flags;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [WW-1:0] word_q, word_d;
  logic [15:0]   cnt_q, cnt_d, n_q, n_d, eff_n;
  logic [2:0]    bit_q, bit_d, byte_q, byte_d;
  logic          line_q, line_d;
  logic          pop, push, full;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  // A full FIFO can still take a word in the cycle the head is popped.
  assign push  = result_valid && (!full || pop);
  // A zero period would never terminate a bit, so it runs as one cycle.
  assign eff_n = (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;

  // FIFO storage write.
  // NOTE: the storage array has no reset; emptiness is tracked by the pointers
  // and count, so clearing the data would only cost flops and fanout.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr_q] <= in_word;
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
      if (result_valid && full && !pop) overflow_q <= 1'b1;
    end
  end

  // Transmitter state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      line_q  <= line_d;
    end
  end

  // Next-state logic; line_d is the line level for the state being entered,
  // so the registered output lines up with the state register.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    line_d  = line_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          word_d  = mem[rd_ptr_q];
          byte_d  = '0;
          bit_d   = '0;
          n_d     = eff_n;
          cnt_d   = eff_n - 16'd1;
          line_d  = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          bit_d   = '0;
          cnt_d   = n_q - 16'd1;
          line_d  = word_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          // Shifting one bit per data bit leaves the next byte in [7:0].
          word_d = word_q >> 1;
          cnt_d  = n_q - 16'd1;
          if (bit_q == 3'd7) begin
            line_d  = 1'b1;
            state_d = STOP;
          end else begin
            bit_d  = bit_q + 3'd1;
            line_d = word_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          if (byte_q == 3'(NBYTES - 1)) begin
            line_d  = 1'b1;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 3'd1;
            n_d     = eff_n;
            cnt_d   = eff_n - 16'd1;
            line_d  = 1'b0;
            state_d = START;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_Tx_Serial = line_q;
  assign tx_busy     = (state_q != IDLE);
  assign fifo_full   = full;
  assign overflow    = overflow_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Testbench for fpu_result_uart_tx: directed words go into a byte scoreboard;
// a UART monitor decodes the line and compares each byte against it.
module tb_fpu_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] clks_per_bit = 16'd4;
  logic        result_valid = 1'b0;
  logic [31:0] result_data = '0;
  logic [4:0]  result_flags = '0;
  logic        o_Tx_Serial, tx_busy, fifo_full, overflow;
  logic [2:0]  fifo_count;

  int checks = 0;
  int failures = 0;
  int mon_n = 4;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];

`ifdef FPU_TX_FLAGS_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  fpu_result_uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clks_per_bit(clks_per_bit),
    .result_valid(result_valid), .result_data(result_data),
    .result_flags(result_flags), .o_Tx_Serial(o_Tx_Serial),
    .tx_busy(tx_busy), .fifo_full(fifo_full), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One-cycle result pulse; accepted words are queued as expected bytes.
  task automatic pulse(input logic [31:0] d, input logic [4:0] f, input bit accept);
    result_valid = 1'b1;
    result_data  = d;
    result_flags = f;
    if (accept) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(d[8*b +: 8]);
      if (NB == 5) exp_q.push_back({3'b000, f});
    end
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((tx_busy || fifo_count != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL %s timeout busy=%0b count=%0d", name, tx_busy, fifo_count);
    end
    repeat (4) @(negedge clk);
  endtask

  // Counts busy cycles starting at a negedge where the first start bit shows.
  task automatic measure_busy(input string name, input int exp_cycles, input int switch_at);
    int n = 0;
    while (tx_busy && n < 5000) begin
      if (n == switch_at) clks_per_bit = 16'd9;
      n++;
      @(negedge clk);
    end
    check(name, 64'(n), 64'(exp_cycles));
  endtask

  // UART monitor: on the first low sample of a start bit, sample each data
  // bit and the stop bit mid-period, then score the byte.
  initial begin
    logic [7:0] rx;
    int pos, tgt;
    forever begin
      @(negedge clk);
      if (mon_en && o_Tx_Serial === 1'b0) begin
        pos = 0;
        for (int k = 0; k < 9; k++) begin
          tgt = mon_n + k * mon_n + mon_n / 2;
          while (pos < tgt) begin
            @(negedge clk);
            pos++;
          end
          if (k < 8) rx[k] = o_Tx_Serial;
          else check("stop_bit", 64'(o_Tx_Serial), 64'd1);
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%02h required=none", rx);
        end else begin
          check("uart_byte", 64'(rx), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int lows;
    // Reset state, with result_valid held high to show it is ignored.
    result_valid = 1'b1;
    result_data  = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    result_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rst_line", 64'(o_Tx_Serial), 64'd1);
    check("rst_busy", 64'(tx_busy), 64'd0);
    check("rst_full", 64'(fifo_full), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);

    // Single word at 4 clocks per bit: pop one cycle after capture.
    clks_per_bit = 16'd4; mon_n = 4;
    pulse(32'h3C00_4248, 5'b00001, 1'b1);
    check("pre_pop_busy", 64'(tx_busy), 64'd0);
    check("pre_pop_count", 64'(fifo_count), 64'd1);
    @(negedge clk);
    check("start_latency_line", 64'(o_Tx_Serial), 64'd0);
    check("start_latency_count", 64'(fifo_count), 64'd0);
    measure_busy("busy_len_n4", NB * 40, -1);
    wait_drain("drain_n4");

    // Zero period runs one-cycle bits, ten-cycle frames.
    clks_per_bit = 16'd0; mon_n = 1;
    pulse(32'hA55A_FF01, 5'b10110, 1'b1);
    @(negedge clk);
    measure_busy("busy_len_n0", NB * 10, -1);
    wait_drain("drain_n0");

    // Five back-to-back pulses: all accepted, nothing dropped.
    clks_per_bit = 16'd1; mon_n = 1;
    pulse(32'h0000_0001, 5'd1, 1'b1);
    pulse(32'h1234_5678, 5'd2, 1'b1);
    pulse(32'h9ABC_DEF0, 5'd3, 1'b1);
    pulse(32'hFFFF_0000, 5'd4, 1'b1);
    pulse(32'h8000_0080, 5'd5, 1'b1);
    check("five_overflow", 64'(overflow), 64'd0);
    check("five_full", 64'(fifo_full), 64'd1);
    wait_drain("drain_five");
    check("five_overflow_after", 64'(overflow), 64'd0);

    // Full FIFO with a push in the same cycle as the idle pop.
    pulse(32'h0101_0101, 5'd0, 1'b1);
    pulse(32'h0202_0202, 5'd0, 1'b1);
    pulse(32'h0303_0303, 5'd0, 1'b1);
    pulse(32'h0404_0404, 5'd0, 1'b1);
    pulse(32'h0505_0505, 5'd0, 1'b1);
    begin
      int n = 0;
      while (tx_busy && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("idle_gap_seen", 64'(tx_busy), 64'd0);
    end
    check("idle_full", 64'(fifo_full), 64'd1);
    pulse(32'hC0DE_600D, 5'd31, 1'b1);
    check("push_pop_full_count", 64'(fifo_count), 64'd4);
    check("push_pop_full_overflow", 64'(overflow), 64'd0);
    wait_drain("drain_pushpop");

    // Six back-to-back pulses: the sixth is dropped, overflow sticks.
    pulse(32'h1111_1111, 5'd0, 1'b1);
    pulse(32'h2222_2222, 5'd0, 1'b1);
    pulse(32'h3333_3333, 5'd0, 1'b1);
    pulse(32'h4444_4444, 5'd0, 1'b1);
    pulse(32'h5555_5555, 5'd0, 1'b1);
    pulse(32'h6666_6666, 5'd0, 1'b0);
    check("six_overflow", 64'(overflow), 64'd1);
    check("six_count", 64'(fifo_count), 64'd4);
    wait_drain("drain_six");
    check("six_overflow_sticky", 64'(overflow), 64'd1);

    // Period change during the last byte must not disturb it.
    clks_per_bit = 16'd4; mon_n = 4;
    pulse(32'h1122_3344, 5'd9, 1'b1);
    @(negedge clk);
    measure_busy("busy_len_period_change", NB * 40, (NB - 1) * 40 + 10);
    wait_drain("drain_period_change");
    clks_per_bit = 16'd4;

    // Reset during DATA of byte 2 aborts the frame and empties the FIFO.
    mon_en = 1'b0;
    pulse(32'h0F0F_0F0F, 5'd0, 1'b0);
    pulse(32'hF0F0_F0F0, 5'd0, 1'b0);
    repeat (88) @(negedge clk);
    check("pre_rst_count", 64'(fifo_count), 64'd1);
    rst = 1'b1;
    result_valid = 1'b1;
    @(negedge clk);
    check("mid_rst_line", 64'(o_Tx_Serial), 64'd1);
    check("mid_rst_count", 64'(fifo_count), 64'd0);
    check("mid_rst_busy", 64'(tx_busy), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    result_valid = 1'b0;
    check("rst_valid_ignored", 64'(fifo_count), 64'd0);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (o_Tx_Serial !== 1'b1) lows++;
    end
    check("post_rst_line_quiet", 64'(lows), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
